// File: rtl/and_ff_arbiter_if.sv
// Requester-side bundle of the and_ff arbiter: level requests and operands go in,
// one-hot grant and result strobe come back.
interface and_ff_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] a_in;
  logic [NREQ-1:0] b_in;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rsp_valid;
  logic            rsp_z;

  modport master (
    output req, a_in, b_in,
    input  gnt, rsp_valid, rsp_z
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, rsp_valid, rsp_z
  );
endinterface

// File: rtl/and_ff_arbiter.sv
// Round-robin arbiter sharing one registered-AND (and_ff) among NREQ requesters:
// grant and latch operands, pulse the enable for one cycle, return the result.
module and_ff_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  and_ff_arbiter_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic             ff_enable,
  output logic             ff_a,
  output logic             ff_b,
  input  logic             ff_z
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx_p0;
  logic             op_a_p0;
  logic             op_b_p0;

  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] win_next;
  int               pos_i;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr; first set request wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    pos_i   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos_i = int'(rr_ptr) + k;
      if (pos_i >= NREQ) pos_i = pos_i - NREQ;
      if (!win_vld && bus.req[pos_i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(pos_i);
      end
    end
  end

  assign win_next = wrap_inc(win_idx);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant/latch stage: operands of the winner captured at the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      idx_p0   <= '0;
      op_a_p0  <= 1'b0;
      op_b_p0  <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        idx_p0  <= win_idx;
        op_a_p0 <= bus.a_in[win_idx];
        op_b_p0 <= bus.b_in[win_idx];
        rr_ptr  <= win_next;
      end
      if (state == CAPTURE) op_count <= sat_inc(op_count);
    end
  end

  // Grant is combinational from req, so it must be masked while reset is held.
  always_comb begin
    bus.gnt = '0;
    if (rst_n && state == IDLE && win_vld) bus.gnt[win_idx] = 1'b1;
  end

  // Issue/capture stage: and_ff samples in ISSUE, its output is returned in CAPTURE.
  always_comb begin
    bus.rsp_valid = '0;
    if (state == CAPTURE) bus.rsp_valid[idx_p0] = 1'b1;
  end

  assign bus.rsp_z = (state == CAPTURE) & ff_z;
  assign ff_enable = (state == ISSUE);
  assign ff_a      = op_a_p0;
  assign ff_b      = op_b_p0;
  assign busy      = (state == ISSUE) || (state == CAPTURE);

endmodule

// File: tb/tb_and_ff_arbiter.sv
// Directed bench for and_ff_arbiter with a behavioural and_ff attached; a second
// instance with a 2-bit counter exercises saturation.
module tb_and_ff_arbiter;

  logic clk;
  logic rst_n;

  and_ff_arbiter_if #(.NREQ(4)) bus ();
  and_ff_arbiter_if #(.NREQ(4)) bus2 ();

  logic        busy, ff_enable, ff_a, ff_b, ff_z;
  logic [15:0] op_count;
  logic        busy2, ff_enable2, ff_a2, ff_b2, ff_z2;
  logic [1:0]  op_count2;

  int n_cmp;
  int n_err;

  and_ff_arbiter #(.NREQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .op_count(op_count),
    .ff_enable(ff_enable), .ff_a(ff_a), .ff_b(ff_b), .ff_z(ff_z)
  );

  and_ff_arbiter #(.NREQ(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .busy(busy2), .op_count(op_count2),
    .ff_enable(ff_enable2), .ff_a(ff_a2), .ff_b(ff_b2), .ff_z(ff_z2)
  );

  // Behavioural and_ff: registered AND with enable, same clock and reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_z  <= 1'b0;
      ff_z2 <= 1'b0;
    end else begin
      if (ff_enable)  ff_z  <= ff_a & ff_b;
      if (ff_enable2) ff_z2 <= ff_a2 & ff_b2;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [3:0] b_pat;
  int         exp_w [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    b_pat = 4'b0101;
    exp_w = '{0, 1, 2, 3, 0};

    // Test 1: reset held with all requests up.
    rst_n = 1'b0;
    bus.req = 4'b1111; bus.a_in = 4'b0000; bus.b_in = 4'b0000;
    bus2.req = 4'b0000; bus2.a_in = 4'b1111; bus2.b_in = 4'b1111;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("rst_gnt", 32'(bus.gnt), 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_ff_enable", 32'(ff_enable), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_op_count", 32'(op_count), 32'h0);
      step();
    end
    bus.req = 4'b0000;
    rst_n = 1'b1;

    // Test 2: single op from requester 0.
    bus.req = 4'b0001; bus.a_in = 4'b0001; bus.b_in = 4'b0001;
    #1;
    check("t2_gnt", 32'(bus.gnt), 32'h1);
    check("t2_busy_idle", 32'(busy), 32'h0);
    step();
    bus.req = 4'b0000;
    #1;
    check("t2_issue_gnt", 32'(bus.gnt), 32'h0);
    check("t2_ff_enable", 32'(ff_enable), 32'h1);
    check("t2_ff_a", 32'(ff_a), 32'h1);
    check("t2_ff_b", 32'(ff_b), 32'h1);
    check("t2_busy_issue", 32'(busy), 32'h1);
    step();
    check("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t2_rsp_z", 32'(bus.rsp_z), 32'h1);
    check("t2_cap_ff_enable", 32'(ff_enable), 32'h0);
    check("t2_busy_cap", 32'(busy), 32'h1);
    step();
    check("t2_op_count", 32'(op_count), 32'h1);
    check("t2_rsp_idle", 32'(bus.rsp_valid), 32'h0);
    check("t2_rsp_z_idle", 32'(bus.rsp_z), 32'h0);

    // Test 3: all requesting, round robin 0,1,2,3,0.
    do_reset();
    bus.req = 4'b1111; bus.a_in = 4'b1111; bus.b_in = b_pat;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_gnt", 32'(bus.gnt), 32'(1) << exp_w[i]);
      step();
      check("t3_ff_b", 32'(ff_b), 32'(b_pat[exp_w[i]]));
      check("t3_issue_gnt", 32'(bus.gnt), 32'h0);
      step();
      check("t3_rsp_valid", 32'(bus.rsp_valid), 32'(1) << exp_w[i]);
      check("t3_rsp_z", 32'(bus.rsp_z), 32'(b_pat[exp_w[i]]));
      step();
    end
    check("t3_op_count", 32'(op_count), 32'd5);

    // Test 4: grant to 2, then req=0011 -> 0 then 1.
    bus.req = 4'b0100;
    #1;
    check("t4_gnt2", 32'(bus.gnt), 32'h4);
    step();
    bus.req = 4'b0011;
    step();
    step();
    check("t4_gnt0", 32'(bus.gnt), 32'h1);
    step(); step(); step();
    check("t4_gnt1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    step(); step(); step();

    // Test 5: reset pulse while requester 1 is in ISSUE.
    do_reset();
    bus.req = 4'b0010;
    #1;
    check("t5_gnt1", 32'(bus.gnt), 32'h2);
    step();
    bus.req = 4'b0000;
    check("t5_in_issue", 32'(ff_enable), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ff_enable", 32'(ff_enable), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t5_no_rsp", 32'(bus.rsp_valid), 32'h0);
      step();
    end
    check("t5_op_count", 32'(op_count), 32'h0);
    bus.req = 4'b0011;
    #1;
    check("t5_gnt0", 32'(bus.gnt), 32'h1);
    step();
    bus.req = 4'b0000;
    step(); step();

    // Test 6: 2-bit counter saturates at 3.
    do_reset();
    bus2.req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(); step(); step();
      check("t6_op_count2", 32'(op_count2), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    bus2.req = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
